// File: rtl/peak_bin_tracker.sv
// Streams NBINS complex FFT bins per frame, reports strongest and second-strongest bin power/index.
// Latency: out_valid rises 2 edges after the last beat is accepted; frame period >= NBINS+3 cycles.
// Backpressure: in_ready drops from last beat until the result handshake; result held while out_ready low.
module peak_bin_tracker #(
    parameter int NBINS = 16,
    parameter int DW    = 16,
    parameter int IW    = $clog2(NBINS),
    parameter int PW    = 2 * DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_data,
    input  logic [PW-1:0]   thresh,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   peak_idx,
    output logic [PW-1:0]   peak_pwr,
    output logic [IW-1:0]   sec_idx,
    output logic [PW-1:0]   sec_pwr,
    output logic            above_thresh
);

    typedef enum logic [1:0] {ACCUM, FLUSH, LOAD, RESULT} state_t;

    localparam int LAST = NBINS - 1;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          in_rdy_q, in_rdy_d;
    logic          p_vld_q, p_vld_d;
    logic [PW-1:0] p_q, p_d;
    logic [IW-1:0] pidx_q, pidx_d;
    logic [PW-1:0] max_q, max_d;
    logic [IW-1:0] max_idx_q, max_idx_d;
    logic [PW-1:0] sec_q, sec_d;
    logic [IW-1:0] sec_idx_q, sec_idx_d;
    logic          sec_vld_q, sec_vld_d;
    logic          out_vld_q, out_vld_d;
    logic [IW-1:0] o_peak_idx_q, o_peak_idx_d;
    logic [PW-1:0] o_peak_pwr_q, o_peak_pwr_d;
    logic [IW-1:0] o_sec_idx_q, o_sec_idx_d;
    logic [PW-1:0] o_sec_pwr_q, o_sec_pwr_d;
    logic          o_above_q, o_above_d;

    logic                 accept;
    logic signed [DW-1:0] re, im;
    logic signed [PW-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [PW-1:0]        pwr;

    // Each square is non-negative and at most 2^(2DW-2), so the unsigned sum never wraps.
    always_comb begin
        re     = in_data[2*DW-1:DW];
        im     = in_data[DW-1:0];
        re_ext = PW'(re);
        im_ext = PW'(im);
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
        pwr    = $unsigned(re_sq) + $unsigned(im_sq);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_rdy_d     = in_rdy_q;
        p_vld_d      = 1'b0;
        p_d          = p_q;
        pidx_d       = pidx_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        sec_d        = sec_q;
        sec_idx_d    = sec_idx_q;
        sec_vld_d    = sec_vld_q;
        out_vld_d    = out_vld_q;
        o_peak_idx_d = o_peak_idx_q;
        o_peak_pwr_d = o_peak_pwr_q;
        o_sec_idx_d  = o_sec_idx_q;
        o_sec_pwr_d  = o_sec_pwr_q;
        o_above_d    = o_above_q;

        accept = in_valid & in_rdy_q;

        if (accept) begin
            p_vld_d = 1'b1;
            p_d     = pwr;
            pidx_d  = cnt_q;
            cnt_d   = cnt_q + IW'(1);
        end

        // Strict compares: on equal power the earlier (lower) index keeps its place.
        if (p_vld_q) begin
            if (pidx_q == '0) begin
                max_d     = p_q;
                max_idx_d = pidx_q;
                sec_vld_d = 1'b0;
            end else if (p_q > max_q) begin
                sec_d     = max_q;
                sec_idx_d = max_idx_q;
                sec_vld_d = 1'b1;
                max_d     = p_q;
                max_idx_d = pidx_q;
            end else if (!sec_vld_q || (p_q > sec_q)) begin
                sec_d     = p_q;
                sec_idx_d = pidx_q;
                sec_vld_d = 1'b1;
            end
        end

        case (state_q)
            ACCUM: begin
                if (accept && (cnt_q == IW'(LAST))) begin
                    in_rdy_d = 1'b0;
                    state_d  = FLUSH;
                end else begin
                    in_rdy_d = 1'b1;
                end
            end
            FLUSH: state_d = LOAD;
            LOAD: begin
                o_peak_idx_d = max_idx_q;
                o_peak_pwr_d = max_q;
                o_sec_idx_d  = sec_idx_q;
                o_sec_pwr_d  = sec_q;
                o_above_d    = (max_q >= thresh);
                out_vld_d    = 1'b1;
                state_d      = RESULT;
            end
            RESULT: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    in_rdy_d  = 1'b1;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        if (abort) begin
            state_d   = ACCUM;
            cnt_d     = '0;
            in_rdy_d  = 1'b1;
            p_vld_d   = 1'b0;
            max_d     = '0;
            max_idx_d = '0;
            sec_d     = '0;
            sec_idx_d = '0;
            sec_vld_d = 1'b0;
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            in_rdy_q     <= 1'b0;
            p_vld_q      <= 1'b0;
            p_q          <= '0;
            pidx_q       <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            sec_q        <= '0;
            sec_idx_q    <= '0;
            sec_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            o_peak_idx_q <= '0;
            o_peak_pwr_q <= '0;
            o_sec_idx_q  <= '0;
            o_sec_pwr_q  <= '0;
            o_above_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_rdy_q     <= in_rdy_d;
            p_vld_q      <= p_vld_d;
            p_q          <= p_d;
            pidx_q       <= pidx_d;
            max_q        <= max_d;
            max_idx_q    <= max_idx_d;
            sec_q        <= sec_d;
            sec_idx_q    <= sec_idx_d;
            sec_vld_q    <= sec_vld_d;
            out_vld_q    <= out_vld_d;
            o_peak_idx_q <= o_peak_idx_d;
            o_peak_pwr_q <= o_peak_pwr_d;
            o_sec_idx_q  <= o_sec_idx_d;
            o_sec_pwr_q  <= o_sec_pwr_d;
            o_above_q    <= o_above_d;
        end
    end

    assign in_ready     = in_rdy_q;
    assign out_valid    = out_vld_q;
    assign peak_idx     = o_peak_idx_q;
    assign peak_pwr     = o_peak_pwr_q;
    assign sec_idx      = o_sec_idx_q;
    assign sec_pwr      = o_sec_pwr_q;
    assign above_thresh = o_above_q;

endmodule

// File: tb/tb_peak_bin_tracker.sv
// Directed frames with hand-computed results; a monitor pops the expected queue on each result handshake.
module tb_peak_bin_tracker;

    localparam int NB = 16;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*DW-1:0] in_data = '0;
    logic [PW-1:0] thresh = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] peak_idx;
    logic [PW-1:0] peak_pwr;
    logic [IW-1:0] sec_idx;
    logic [PW-1:0] sec_pwr;
    logic          above_thresh;

    peak_bin_tracker #(.NBINS(NB), .DW(DW)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready),
        .peak_idx(peak_idx), .peak_pwr(peak_pwr),
        .sec_idx(sec_idx), .sec_pwr(sec_pwr),
        .above_thresh(above_thresh)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] pi;
        logic [PW-1:0] pp;
        logic [IW-1:0] si;
        logic [PW-1:0] sp;
        logic          at;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] frame [NB];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = re[15:0];
        i = im[15:0];
        return {r, i};
    endfunction

    task automatic fill(input int re, input int im);
        for (int k = 0; k < NB; k++) frame[k] = mk(re, im);
    endtask

    task automatic push_exp(input int pi, input logic [PW-1:0] pp, input int si,
                            input logic [PW-1:0] sp, input logic at);
        exp_t e;
        e.pi = pi[IW-1:0];
        e.pp = pp;
        e.si = si[IW-1:0];
        e.sp = sp;
        e.at = at;
        expq.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat's accepting edge.
    task automatic send_beats(input int n, input bit gaps);
        int k;
        for (int b = 0; b < n; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = frame[b];
            k = 0;
            while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
            if (k == 200) begin
                n_chk++;
                $display("FAIL in_ready_timeout: beat %0d never accepted within 200 cycles", b);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = $urandom;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (expq.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
        chk("result_drained", expq.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        chk(name, out_valid, 1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {in_ready, out_valid, peak_idx, sec_idx, above_thresh}, 0);
        chk({name, "_pwr"}, {peak_pwr, sec_pwr}, 0);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_hs++;
            if (expq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: peak_idx=%0d peak_pwr=%0d with no result pending",
                         peak_idx, peak_pwr);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("peak_idx", peak_idx, e.pi);
                chk("peak_pwr", peak_pwr, e.pp);
                chk("sec_idx", sec_idx, e.si);
                chk("sec_pwr", sec_pwr, e.sp);
                chk("above_thresh", above_thresh, e.at);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1);

        // 1: single strong bin, latency check
        thresh = 32'd100000;
        out_ready = 1'b1;
        fill(10, 10);
        frame[5] = mk(300, -400);
        push_exp(5, 32'd250000, 0, 32'd200, 1'b1);
        send_beats(NB, 1'b0);
        chk("t1_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        chk("t1_valid_e1", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid_e2", out_valid, 1);
        wait_drain();

        // 2: all zero, threshold zero
        thresh = 32'd0;
        fill(0, 0);
        push_exp(0, 32'd0, 1, 32'd0, 1'b1);
        send_beats(NB, 1'b0);
        wait_drain();

        // 3: maximal power, tie resolved to lower index, threshold equal to peak
        thresh = 32'h8000_0000;
        fill(1, 0);
        frame[3] = mk(-32768, -32768);
        frame[9] = mk(-32768, -32768);
        push_exp(3, 32'h8000_0000, 9, 32'h8000_0000, 1'b1);
        send_beats(NB, 1'b0);
        wait_drain();

        // 4: gapped input, result held under backpressure
        thresh = 32'd100000;
        out_ready = 1'b0;
        for (int k = 0; k < NB; k++) frame[k] = mk(k * 10, 0);
        push_exp(15, 32'd22500, 14, 32'd19600, 1'b0);
        send_beats(NB, 1'b1);
        wait_valid("t4_valid");
        repeat (20) begin
            @(posedge clk); #1;
            chk("t4_hold_ctl", {out_valid, in_ready, peak_idx, sec_idx, above_thresh},
                {1'b1, 1'b0, 4'd15, 4'd14, 1'b0});
            chk("t4_hold_pwr", {peak_pwr, sec_pwr}, {32'd22500, 32'd19600});
        end
        out_ready = 1'b1;
        wait_drain();
        fill(10, 10);
        frame[5] = mk(300, -400);
        push_exp(5, 32'd250000, 0, 32'd200, 1'b1);
        send_beats(NB, 1'b1);
        wait_drain();

        // 5: abort after 7 beats (with a same-cycle beat), then a fresh frame
        hs0 = n_hs;
        fill(2, 1);
        frame[3] = mk(30000, 0);
        send_beats(7, 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = mk(32767, 0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t5_in_ready_after_abort", in_ready, 1);
        fill(2, 1);
        frame[12] = mk(1000, 0);
        push_exp(12, 32'd1000000, 0, 32'd5, 1'b1);
        send_beats(NB, 1'b0);
        wait_drain();
        repeat (5) begin @(posedge clk); #1; end
        chk("t5_one_result", n_hs - hs0, 1);

        // 6a: reset mid-frame
        fill(10, 10);
        send_beats(5, 1'b0);
        rst = 1'b0;
        #1;
        chk_zero("t6a_in_reset");
        @(posedge clk); #1;
        chk("t6a_in_ready_held", in_ready, 0);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("t6a_in_ready_release", in_ready, 1);
        frame[5] = mk(300, -400);
        push_exp(5, 32'd250000, 0, 32'd200, 1'b1);
        send_beats(NB, 1'b0);
        wait_drain();

        // 6b: reset while a result is pending
        out_ready = 1'b0;
        fill(10, 10);
        frame[7] = mk(0, 500);
        send_beats(NB, 1'b0);
        wait_valid("t6b_valid");
        rst = 1'b0;
        #1;
        chk_zero("t6b_in_reset");
        @(posedge clk); #1;
        #3 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6b_in_ready_release", {in_ready, out_valid}, 2'b10);
        fill(0, 0);
        frame[15] = mk(-1, -1);
        push_exp(15, 32'd2, 0, 32'd0, 1'b0);
        send_beats(NB, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
